// File: rtl/xf100_exu_wbck_pkg.sv
// Shared widths, limits and grant encoding for the EXU write-back stage.
// Widths default to the core values: 32-bit data, 5-bit register index.
package xf100_exu_wbck_pkg;

  localparam int WBCK_XLEN       = 32;
  localparam int WBCK_RFIDX_W    = 5;
  localparam int WBCK_STARVE_MAX = 4;

  localparam int STARVE_W = 4;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_ALU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_e;

endpackage

// File: rtl/xf100_wbck_arb.sv
// 2-way write-back arbiter: LSU priority, ALU forced through after STARVE_MAX lost conflicts.
// Grants are combinational (0 cycles); no grant while rst or hold is high.
module xf100_wbck_arb
  import xf100_exu_wbck_pkg::*;
#(
  parameter int STARVE_MAX = WBCK_STARVE_MAX
) (
  input  logic clk,
  input  logic rst,
  input  logic i_hold,
  input  logic i_alu_vld,
  input  logic i_lsu_vld,
  output logic o_grant_alu,
  output logic o_grant_lsu
);

  logic [STARVE_W-1:0] r_starve_cnt;
  logic [STARVE_W-1:0] w_starve_nxt;
  grant_e              w_gnt;

  always_comb begin
    w_gnt        = GNT_NONE;
    w_starve_nxt = r_starve_cnt;
    if (!rst && !i_hold) begin
      if (i_alu_vld && i_lsu_vld) begin
        // Counter only advances on real conflicts; LSU-alone cycles leave it untouched.
        if (r_starve_cnt < STARVE_W'(STARVE_MAX)) begin
          w_gnt        = GNT_LSU;
          w_starve_nxt = r_starve_cnt + STARVE_W'(1);
        end else begin
          w_gnt        = GNT_ALU;
          w_starve_nxt = '0;
        end
      end else if (i_lsu_vld) begin
        w_gnt = GNT_LSU;
      end else if (i_alu_vld) begin
        w_gnt        = GNT_ALU;
        w_starve_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else begin
      r_starve_cnt <= w_starve_nxt;
    end
  end

  assign o_grant_alu = (w_gnt == GNT_ALU);
  assign o_grant_lsu = (w_gnt == GNT_LSU);

endmodule

// File: rtl/xf100_exu_wbck.sv
// EXU write-back: arbitrates ALU/LSU results into one registered regfile write, 1 cycle accept-to-write.
// Hold freezes the stage and drops both readys; XF100_WBCK_BYPASS_EN adds forwarding outputs.
module xf100_exu_wbck
  import xf100_exu_wbck_pkg::*;
#(
  parameter int XLEN       = WBCK_XLEN,
  parameter int RFIDX_W    = WBCK_RFIDX_W,
  parameter int STARVE_MAX = WBCK_STARVE_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wbck_i_hold,
  input  logic               alu_i_wbck_valid,
  output logic               alu_o_wbck_ready,
  input  logic [XLEN-1:0]    alu_i_wbck_data,
  input  logic [RFIDX_W-1:0] alu_i_wbck_rdidx,
  input  logic               lsu_i_wbck_valid,
  output logic               lsu_o_wbck_ready,
  input  logic [XLEN-1:0]    lsu_i_wbck_data,
  input  logic [RFIDX_W-1:0] lsu_i_wbck_rdidx,
  output logic               rf_o_wr_en,
  output logic [XLEN-1:0]    rf_o_wr_data,
  output logic [RFIDX_W-1:0] rf_o_wr_rdidx,
  output logic               wbck_o_busy
`ifdef XF100_WBCK_BYPASS_EN
  ,
  output logic               wbck_o_byp_valid,
  output logic [RFIDX_W-1:0] wbck_o_byp_rdidx,
  output logic [XLEN-1:0]    wbck_o_byp_data
`endif
);

  logic               w_grant_alu;
  logic               w_grant_lsu;
  logic               r_wb_vld;
  logic [XLEN-1:0]    r_wb_data;
  logic [RFIDX_W-1:0] r_wb_idx;

  xf100_wbck_arb #(
    .STARVE_MAX (STARVE_MAX)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_hold      (wbck_i_hold),
    .i_alu_vld   (alu_i_wbck_valid),
    .i_lsu_vld   (lsu_i_wbck_valid),
    .o_grant_alu (w_grant_alu),
    .o_grant_lsu (w_grant_lsu)
  );

  assign alu_o_wbck_ready = w_grant_alu;
  assign lsu_o_wbck_ready = w_grant_lsu;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_vld  <= 1'b0;
      r_wb_data <= '0;
      r_wb_idx  <= '0;
    end else if (!wbck_i_hold) begin
      r_wb_vld <= w_grant_alu | w_grant_lsu;
      if (w_grant_alu) begin
        r_wb_data <= alu_i_wbck_data;
        r_wb_idx  <= alu_i_wbck_rdidx;
      end else if (w_grant_lsu) begin
        r_wb_data <= lsu_i_wbck_data;
        r_wb_idx  <= lsu_i_wbck_rdidx;
      end
    end
  end

  // rst gates the enable so a pending write is dropped rather than issued during reset.
  assign rf_o_wr_en    = r_wb_vld & ~wbck_i_hold & ~rst & (|r_wb_idx);
  assign rf_o_wr_data  = r_wb_data;
  assign rf_o_wr_rdidx = r_wb_idx;
  assign wbck_o_busy   = r_wb_vld;

`ifdef XF100_WBCK_BYPASS_EN
  assign wbck_o_byp_valid = rf_o_wr_en;
  assign wbck_o_byp_rdidx = rf_o_wr_rdidx;
  assign wbck_o_byp_data  = rf_o_wr_data;
`endif

endmodule

// File: tb/tb_xf100_exu_wbck.sv
// Scoreboard bench for xf100_exu_wbck: inputs driven 1ns after posedge, outputs sampled on negedge.
module tb_xf100_exu_wbck;

  logic        clk = 1'b0;
  logic        rst, hold, av, lv;
  logic [31:0] ad, ld;
  logic [4:0]  ai, li;
  wire         ar, lr, we, busy;
  wire  [31:0] wd;
  wire  [4:0]  wi;
`ifdef XF100_WBCK_BYPASS_EN
  wire         byp_v;
  wire  [4:0]  byp_i;
  wire  [31:0] byp_d;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  total = 0;
  int  bad   = 0;

  always #5 clk = ~clk;

  xf100_exu_wbck #(.XLEN(32), .RFIDX_W(5), .STARVE_MAX(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .wbck_i_hold      (hold),
    .alu_i_wbck_valid (av),
    .alu_o_wbck_ready (ar),
    .alu_i_wbck_data  (ad),
    .alu_i_wbck_rdidx (ai),
    .lsu_i_wbck_valid (lv),
    .lsu_o_wbck_ready (lr),
    .lsu_i_wbck_data  (ld),
    .lsu_i_wbck_rdidx (li),
    .rf_o_wr_en       (we),
    .rf_o_wr_data     (wd),
    .rf_o_wr_rdidx    (wi),
    .wbck_o_busy      (busy)
`ifdef XF100_WBCK_BYPASS_EN
    ,
    .wbck_o_byp_valid (byp_v),
    .wbck_o_byp_rdidx (byp_i),
    .wbck_o_byp_data  (byp_d)
`endif
  );

  task automatic test_reset();
    rst = 1'b1; hold = 1'b0;
    av = 1'b1; ad = 32'h1111_1111; ai = 5'd1;
    lv = 1'b1; ld = 32'h2222_2222; li = 5'd2;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (ar !== 1'b0 || lr !== 1'b0 || we !== 1'b0 || busy !== 1'b0 || wd !== 32'd0 || wi !== 5'd0) begin
        bad++;
        $display("FAIL reset c=%0d got ar=%b lr=%b we=%b busy=%b data=%h idx=%0d want all 0", c, ar, lr, we, busy, wd, wi);
      end
    end
    @(posedge clk); #1;
    rst = 1'b0; av = 1'b0; lv = 1'b0;
  endtask

  task automatic test_single_alu();
    exp_q.delete();
    @(posedge clk); #1;
    av = 1'b1; ad = 32'h1234_5678; ai = 5'd5;
    @(negedge clk);
    total++;
    if (ar !== 1'b1 || lr !== 1'b0) begin
      bad++;
      $display("FAIL single_ready got ar=%b lr=%b want ar=1 lr=0", ar, lr);
    end
    exp_q.push_back({ai, ad});
    @(posedge clk); #1;
    av = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (we !== 1'b1 || wi !== e.idx || wd !== e.data) begin
      bad++;
      $display("FAIL single_wr got en=%b idx=%0d data=%h want en=1 idx=%0d data=%h", we, wi, wd, e.idx, e.data);
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || we !== 1'b0) begin
      bad++;
      $display("FAIL single_drain got busy=%b en=%b want 0 0", busy, we);
    end
  endtask

  task automatic test_x0();
    @(posedge clk); #1;
    lv = 1'b1; ld = 32'hFFFF_FFFF; li = 5'd0;
    @(negedge clk);
    total++;
    if (lr !== 1'b1 || ar !== 1'b0) begin
      bad++;
      $display("FAIL x0_ready got lr=%b ar=%b want lr=1 ar=0", lr, ar);
    end
    @(posedge clk); #1;
    lv = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b0 || busy !== 1'b1 || wi !== 5'd0) begin
      bad++;
      $display("FAIL x0_wr got en=%b busy=%b idx=%0d want en=0 busy=1 idx=0", we, busy, wi);
    end
  endtask

  task automatic test_starve();
    int   na = 0;
    int   nl = 0;
    logic due = 1'b0;
    logic exp_alu;
    exp_q.delete();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      av = 1'b1; ad = 32'hA000_0000 + na; ai = 5'(1 + na % 15);
      lv = 1'b1; ld = 32'hB000_0000 + nl; li = 5'(16 + nl % 15);
      @(negedge clk);
      if (due) begin
        e = exp_q.pop_front();
        total++;
        if (we !== 1'b1 || wi !== e.idx || wd !== e.data) begin
          bad++;
          $display("FAIL starve_wr c=%0d got en=%b idx=%0d data=%h want idx=%0d data=%h", c, we, wi, wd, e.idx, e.data);
        end
      end
      exp_alu = (c % 5 == 4);
      total++;
      if (ar !== exp_alu || lr !== !exp_alu) begin
        bad++;
        $display("FAIL starve_gnt c=%0d got ar=%b lr=%b want ar=%b lr=%b", c, ar, lr, exp_alu, !exp_alu);
      end
      if (exp_alu) begin
        exp_q.push_back({ai, ad}); na++;
      end else begin
        exp_q.push_back({li, ld}); nl++;
      end
      due = 1'b1;
    end
    @(posedge clk); #1;
    av = 1'b0; lv = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (we !== 1'b1 || wi !== e.idx || wd !== e.data) begin
      bad++;
      $display("FAIL starve_last got en=%b idx=%0d data=%h want idx=%0d data=%h", we, wi, wd, e.idx, e.data);
    end
  endtask

  task automatic test_hold();
    exp_q.delete();
    @(posedge clk); #1;
    av = 1'b1; ad = 32'hC0DE_0007; ai = 5'd7;
    @(negedge clk);
    total++;
    if (ar !== 1'b1) begin
      bad++;
      $display("FAIL hold_accept got ar=%b want 1", ar);
    end
    exp_q.push_back({ai, ad});
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      av = 1'b0; hold = 1'b1;
      lv = 1'b1; ld = 32'hD00D_0011; li = 5'd17;
      @(negedge clk);
      total++;
      if (we !== 1'b0 || ar !== 1'b0 || lr !== 1'b0 || busy !== 1'b1 || wi !== 5'd7) begin
        bad++;
        $display("FAIL hold_c%0d got en=%b ar=%b lr=%b busy=%b idx=%0d want 0 0 0 1 7", c, we, ar, lr, busy, wi);
      end
    end
    @(posedge clk); #1;
    hold = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (we !== 1'b1 || wi !== e.idx || wd !== e.data) begin
      bad++;
      $display("FAIL hold_release_wr got en=%b idx=%0d data=%h want idx=%0d data=%h", we, wi, wd, e.idx, e.data);
    end
    total++;
    if (lr !== 1'b1) begin
      bad++;
      $display("FAIL hold_release_gnt got lr=%b want 1", lr);
    end
    exp_q.push_back({li, ld});
    @(posedge clk); #1;
    lv = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (we !== 1'b1 || wi !== e.idx || wd !== e.data) begin
      bad++;
      $display("FAIL hold_next_wr got en=%b idx=%0d data=%h want idx=%0d data=%h", we, wi, wd, e.idx, e.data);
    end
  endtask

  task automatic test_reset_mid();
    logic exp_alu;
    // Two lost conflicts leave the starvation counter at 2 before the reset.
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      av = 1'b1; ad = 32'hE000_0001; ai = 5'd1;
      lv = 1'b1; ld = 32'hF000_0000 + c; li = 5'(20 + c);
      @(negedge clk);
      total++;
      if (lr !== 1'b1 || ar !== 1'b0) begin
        bad++;
        $display("FAIL rmid_pre c=%0d got lr=%b ar=%b want 1 0", c, lr, ar);
      end
    end
    @(posedge clk); #1;
    av = 1'b0; lv = 1'b1; ld = 32'h0000_0999; li = 5'd9;
    @(negedge clk);
    total++;
    if (lr !== 1'b1) begin
      bad++;
      $display("FAIL rmid_accept got lr=%b want 1", lr);
    end
    @(posedge clk); #1;
    rst = 1'b1; lv = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b0 || ar !== 1'b0 || lr !== 1'b0) begin
      bad++;
      $display("FAIL rmid_rst got en=%b idx=%0d ar=%b lr=%b want en=0 ar=0 lr=0", we, wi, ar, lr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b0 || busy !== 1'b0 || wi !== 5'd0 || wd !== 32'd0) begin
      bad++;
      $display("FAIL rmid_after got en=%b busy=%b idx=%0d data=%h want all 0", we, busy, wi, wd);
    end
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      av = 1'b1; ad = 32'h0000_0A00 + c; ai = 5'd3;
      lv = 1'b1; ld = 32'h0000_0B00 + c; li = 5'd4;
      @(negedge clk);
      exp_alu = (c == 4);
      total++;
      if (ar !== exp_alu || lr !== !exp_alu) begin
        bad++;
        $display("FAIL rmid_cnt c=%0d got ar=%b lr=%b want ar=%b lr=%b", c, ar, lr, exp_alu, !exp_alu);
      end
    end
    @(posedge clk); #1;
    av = 1'b0; lv = 1'b0;
    @(negedge clk);
  endtask

`ifdef XF100_WBCK_BYPASS_EN
  task automatic test_bypass();
    @(posedge clk); #1;
    av = 1'b1; ad = 32'h0000_00A5; ai = 5'd3;
    @(negedge clk);
    @(posedge clk); #1;
    av = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b1 || byp_v !== 1'b1 || byp_i !== 5'd3 || byp_d !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL bypass got en=%b bv=%b bi=%0d bd=%h want 1 1 3 000000a5", we, byp_v, byp_i, byp_d);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_x0();
    test_starve();
    test_hold();
    test_reset_mid();
`ifdef XF100_WBCK_BYPASS_EN
    test_bypass();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xf100_exu_wbck.md
Name: xf100_exu_wbck

Overview:
Write-back arbiter that drives the regfile's single write port (wr_en / wr_data / wr_rdidx). It accepts results from two producers, the ALU (short pipe) and the LSU/long pipe, over valid/ready handshakes. It arbitrates with fixed LSU priority plus an anti-starvation counter, and registers the winner for one cycle before the write. It sits at the end of the EXU, after the ALU and LSU result paths, and feeds xf100_exu_regfile directly.

Parameters:
XLEN, 32 (`XF100_XLEN), data width
RFIDX_W, 5 (`XF100_RFIDX_WIDTH), register index width
STARVE_MAX, 4, number of consecutive conflict cycles the LSU may win before the ALU is forced through; legal range 1..15

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, synchronous, active-high
wbck_i_hold  in  1  freeze write-back (debug halt / commit stall)
alu_i_wbck_valid  in  1  ALU result valid
alu_o_wbck_ready  out  1  ALU result accepted this cycle
alu_i_wbck_data  in  XLEN  ALU result
alu_i_wbck_rdidx  in  RFIDX_W  ALU destination index
lsu_i_wbck_valid  in  1  LSU result valid
lsu_o_wbck_ready  out  1  LSU result accepted this cycle
lsu_i_wbck_data  in  XLEN  LSU result
lsu_i_wbck_rdidx  in  RFIDX_W  LSU destination index
rf_o_wr_en  out  1  regfile write enable
rf_o_wr_data  out  XLEN  regfile write data
rf_o_wr_rdidx  out  RFIDX_W  regfile write index
wbck_o_busy  out  1  write-back stage register holds a pending write

Behaviour:
- Interface timing is fixed: one clock (clk); reset rst is synchronous and active-high.
- State:
  - stage register: wb_vld, wb_data, wb_idx
  - starvation counter: starve_cnt, 4 bits
- Reset values: wb_vld=0, wb_data=0, wb_idx=0, starve_cnt=0. All outputs are therefore 0 out of reset, and both readys are 0 while rst is high.
- Handshake:
  - A transfer occurs when valid & ready on a source in the same cycle.
  - A source holds valid, data and rdidx stable until accepted.
  - Readys are combinational from the valids, hold and starve_cnt. Ready must never depend on the same source's data.
- Arbitration (only when wbck_i_hold=0):
  - Only LSU valid: LSU granted.
  - Only ALU valid: ALU granted.
  - Both valid and starve_cnt<STARVE_MAX: LSU granted, starve_cnt+1.
  - Both valid and starve_cnt==STARVE_MAX: ALU granted, starve_cnt=0.
  - Any ALU grant clears starve_cnt. A cycle with no conflict leaves starve_cnt unchanged.
  - At most one grant per cycle; never both readys high.
- Stage register:
  - On a grant, wb_vld=1 and data/idx are captured from the winner.
  - With no grant and hold=0, wb_vld=0.
  - Latency from accept to rf_o_wr_en is exactly 1 cycle; one write per cycle, so the stage drains every cycle.
- Write port:
  - rf_o_wr_en = wb_vld & ~wbck_i_hold & (wb_idx!=0). x0 writes are suppressed but still consume the slot.
  - rf_o_wr_data = wb_data; rf_o_wr_rdidx = wb_idx.
- Hold:
  - Both readys are 0, and the stage register and starve_cnt are frozen.
  - On release, the held write is issued in the first cycle with hold=0, and a new grant can be taken in that same cycle.
- wbck_o_busy = wb_vld.
- Reset mid-operation: a pending write is discarded without issuing, and starve_cnt returns to 0.

Optional Feature:
- Macro: XF100_WBCK_BYPASS_EN.
- When defined, three extra outputs are present: wbck_o_byp_valid (1), wbck_o_byp_rdidx (RFIDX_W) and wbck_o_byp_data (XLEN).
  - They equal rf_o_wr_en / rf_o_wr_rdidx / rf_o_wr_data.
  - Operand fetch uses them to forward the write being committed this cycle, since the regfile read returns the pre-write value.
- When undefined, the ports are absent and there is no extra logic.

Decomposition:
- Use the existing global defines for XLEN and RFIDX_WIDTH.
- Add `XF100_WBCK_STARVE_MAX (default 4) to xf100_defines.v.
- The stage register uses xf100_dfflr instances for data/idx. It needs a new xf100_dffr variant with synchronous active-high reset for wb_vld and starve_cnt.
- One natural sub-module: xf100_wbck_arb (2-way priority arbiter with starvation counter, outputs grant_alu/grant_lsu).

Test Plan:
- Single source: ALU valid, rdidx=5, data=0x1234_5678 → alu_o_wbck_ready=1 same cycle; next cycle rf_o_wr_en=1, idx=5, data=0x1234_5678.
- x0 suppression: LSU valid, rdidx=0, data=0xFFFF_FFFF → accepted; next cycle rf_o_wr_en=0, wbck_o_busy=1.
- Conflict and starvation: ALU and LSU both valid continuously, STARVE_MAX=4 → LSU granted cycles 0-3, ALU granted cycle 4, LSU cycle 5; pattern repeats with period 5.
- Hold: accept ALU rdidx=7, then assert hold for 3 cycles → rf_o_wr_en=0 and both readys=0 during hold; write to x7 issued in the first cycle after release.
- Reset mid-flight: accept LSU rdidx=9, then assert rst the next cycle → no write to x9; all outputs 0; starve_cnt=0.
- Bypass (macro defined): ALU rdidx=3, data=0xA5 → byp_valid=1, byp_rdidx=3, byp_data=0xA5 in the same cycle as rf_o_wr_en.
